button_conditioner: RTL and testbench

Upstream front end for the electronic dice. It takes the raw, asynchronous, bouncing push-button and resynchronises it to clk. It debounces the signal and drives a clean level into the dice's button input. It also produces single-cycle press and release pulses for later stages such as a result latch or display hold.

---
 rtl/dice_pkg.sv | 60 ++++++
 rtl/sync_ff_chain.sv | 25 ++
 rtl/button_conditioner.sv | 100 ++++++++++
 tb/tb_button_conditioner.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the electronic dice: button conditioner
// state encoding and the pip patterns used by the dice stage.
package dice_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } btn_state_t;

    // Dice face values run 1..6 in a 3-bit field.
    localparam int FACE_VAL_W = 3;
    localparam int FACE_PIP_W = 7;

    localparam logic [FACE_VAL_W-1:0] FACE_MIN = 3'd1;
    localparam logic [FACE_VAL_W-1:0] FACE_MAX = 3'd6;

    // Pip layout bits: {tl, tr, ml, c, mr, bl, br}.
    localparam logic [FACE_PIP_W-1:0] PIPS_1 = 7'b0001000;
    localparam logic [FACE_PIP_W-1:0] PIPS_2 = 7'b1000001;
    localparam logic [FACE_PIP_W-1:0] PIPS_3 = 7'b1001001;
    localparam logic [FACE_PIP_W-1:0] PIPS_4 = 7'b1100011;
    localparam logic [FACE_PIP_W-1:0] PIPS_5 = 7'b1101011;
    localparam logic [FACE_PIP_W-1:0] PIPS_6 = 7'b1110111;
    localparam logic [FACE_PIP_W-1:0] PIPS_X = 7'b0000000;

    // Map a face value onto its pip pattern; out-of-range shows blank.
    function automatic logic [FACE_PIP_W-1:0] face_pips(
        input logic [FACE_VAL_W-1:0] v
    );
        logic [FACE_PIP_W-1:0] p;
        p = PIPS_X;
        unique case (v)
            3'd1:    p = PIPS_1;
            3'd2:    p = PIPS_2;
            3'd3:    p = PIPS_3;
            3'd4:    p = PIPS_4;
            3'd5:    p = PIPS_5;
            3'd6:    p = PIPS_6;
            default: p = PIPS_X;
        endcase
        return p;
    endfunction

    // Advance a face value 1..6 with wrap back to 1.
    function automatic logic [FACE_VAL_W-1:0] face_next(
        input logic [FACE_VAL_W-1:0] v
    );
        logic [FACE_VAL_W-1:0] n;
        if (v >= FACE_MAX || v < FACE_MIN) begin
            n = FACE_MIN;
        end else begin
            n = v + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop chain that brings an asynchronous input into the clk
// domain; reused for every asynchronous input of the dice.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift d through the chain; no logic between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: resynchronise, debounce, and emit clean
// level plus single-cycle press/release pulses.
module button_conditioner
    import dice_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic bouncing
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_sync;

    sync_ff_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_raw),
        .q  (btn_sync)
    );

    // Debounce FSM: a level change is accepted only after the
    // opposite level has been seen for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            unique case (state)
                S_LOW: begin
                    if (btn_sync) begin
                        state <= S_RISE_CHK;
                        cnt   <= CNT_ONE;
                    end
                end
                S_RISE_CHK: begin
                    if (!btn_sync) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_HIGH;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!btn_sync) begin
                        state <= S_FALL_CHK;
                        cnt   <= CNT_ONE;
                    end
                end
                S_FALL_CHK: begin
                    if (btn_sync) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_LOW;
                        cnt         <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= S_LOW;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

    // Qualification in progress whenever a check state is active.
    always_comb begin
        bouncing = (state == S_RISE_CHK) || (state == S_FALL_CHK);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a
// sliding-window reference model of the debounced level.
module tb_button_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level, btn_press, btn_release, bouncing;

    logic rst2 = 1'b1;
    logic btn_raw2 = 1'b0;
    logic level2, press2, release2, bouncing2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .bouncing(bouncing)
    );

    button_conditioner #(
        .SYNC_STAGES(3),
        .DEBOUNCE_CYCLES(2)
    ) dut2 (
        .clk(clk),
        .rst(rst2),
        .btn_raw(btn_raw2),
        .btn_level(level2),
        .btn_press(press2),
        .btn_release(release2),
        .bouncing(bouncing2)
    );

    // Reference model: a delay line stands in for the synchroniser,
    // and the level flips once the last DEB synchronised samples all
    // disagree with it.
    bit dly[$];
    bit hist[$];
    bit m_level, m_press, m_release, m_bounce;

    task automatic model_reset();
        dly.delete();
        for (int i = 0; i < SYNC; i++) dly.push_back(1'b0);
        hist.delete();
        m_level   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_bounce  = 1'b0;
    endtask

    task automatic tick(input bit raw, input bit r);
        bit s;
        bit all_opp;
        int run;
        btn_raw = raw;
        rst     = r;
        @(posedge clk);
        m_press   = 1'b0;
        m_release = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            s = dly.pop_front();
            dly.push_back(raw);
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (hist.size() == DEB) begin
                all_opp = 1'b1;
                foreach (hist[i]) if (hist[i] == m_level) all_opp = 1'b0;
                if (all_opp) begin
                    m_level = !m_level;
                    if (m_level) m_press = 1'b1;
                    else m_release = 1'b1;
                end
            end
        end
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != m_level) run++;
            else break;
        end
        m_bounce = (run > 0);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {btn_level, btn_press, btn_release, bouncing};
    endfunction

    function automatic logic [3:0] expv();
        return {m_level, m_press, m_release, m_bounce};
    endfunction

    task automatic test_reset();
        int press_at;
        int npress;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs() !== 4'b0000) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, obs());
            end
        end
        press_at = -1;
        npress = 0;
        for (int i = 1; i <= 25; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL reset_model edge=%0d got=%b want=%b", i, obs(), expv());
            end
            if (btn_press === 1'b1) begin
                npress++;
                if (press_at < 0) press_at = i;
            end
        end
        checks++;
        if (press_at !== 18 || npress !== 1) begin
            fails++;
            $display("FAIL reset_latency got=%0d/%0d want=18/1", press_at, npress);
        end
    endtask

    task automatic test_clean_press();
        int press_at, rel_at, lvl_hi;
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
        press_at = -1;
        lvl_hi = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL clean_rise edge=%0d got=%b want=%b", i, obs(), expv());
            end
            if (btn_press === 1'b1 && press_at < 0) press_at = i;
            if (btn_level === 1'b1) lvl_hi++;
        end
        rel_at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL clean_fall edge=%0d got=%b want=%b", i, obs(), expv());
            end
            if (btn_release === 1'b1 && rel_at < 0) rel_at = i;
        end
        checks++;
        if (press_at !== 18 || rel_at !== 18 || lvl_hi !== 83) begin
            fails++;
            $display("FAIL clean_latency got=%0d/%0d/%0d want=18/18/83",
                     press_at, rel_at, lvl_hi);
        end
    endtask

    task automatic test_bounce();
        int npress, press_at, btog;
        logic prev_b;
        npress = 0;
        press_at = -1;
        btog = 0;
        prev_b = bouncing;
        for (int i = 0; i < 70; i++) begin
            tick((i >= 30) ? 1'b1 : (((i / 3) % 2) == 0), 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL bounce_model cyc=%0d got=%b want=%b", i, obs(), expv());
            end
            if (bouncing !== prev_b) btog++;
            prev_b = bouncing;
            if (btn_press === 1'b1) begin
                npress++;
                press_at = i - 29;
            end
        end
        checks++;
        if (npress !== 1 || press_at !== 18 || btog < 4) begin
            fails++;
            $display("FAIL bounce_summary got=%0d/%0d/%0d want=1/18/>=4",
                     npress, press_at, btog);
        end
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        int np, nr, lvl;
        np = 0;
        nr = 0;
        for (int i = 0; i < 16 + 40; i++) begin
            tick(i < 16, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL bound16_model cyc=%0d got=%b want=%b", i, obs(), expv());
            end
            if (btn_press === 1'b1) np++;
            if (btn_release === 1'b1) nr++;
        end
        checks++;
        if (np !== 1 || nr !== 1) begin
            fails++;
            $display("FAIL bound16 got=%0d/%0d want=1/1", np, nr);
        end
        np = 0;
        lvl = 0;
        for (int i = 0; i < 15 + 40; i++) begin
            tick(i < 15, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL bound15_model cyc=%0d got=%b want=%b", i, obs(), expv());
            end
            if (btn_press === 1'b1) np++;
            if (btn_level === 1'b1) lvl++;
        end
        checks++;
        if (np !== 0 || lvl !== 0) begin
            fails++;
            $display("FAIL bound15 got=%0d/%0d want=0/0", np, lvl);
        end
    endtask

    task automatic test_reset_mid_check();
        int press_at, npulse;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0);
            if (btn_press === 1'b1 || btn_release === 1'b1) npulse++;
        end
        checks++;
        if (bouncing !== 1'b1 || btn_level !== 1'b0) begin
            fails++;
            $display("FAIL midchk_pre got=%b/%b want=1/0", bouncing, btn_level);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (obs() !== 4'b0000 || npulse !== 0) begin
            fails++;
            $display("FAIL midchk_reset got=%b/%0d want=0000/0", obs(), npulse);
        end
        press_at = -1;
        for (int i = 1; i <= 25; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL midchk_model edge=%0d got=%b want=%b", i, obs(), expv());
            end
            if (btn_press === 1'b1 && press_at < 0) press_at = i;
        end
        checks++;
        if (press_at !== 18) begin
            fails++;
            $display("FAIL midchk_latency got=%0d want=18", press_at);
        end
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit v;
        int len;
        for (int seg = 0; seg < 80; seg++) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                tick(v, ($urandom_range(0, 199) == 0));
                checks++;
                if (obs() !== expv()) begin
                    fails++;
                    $display("FAIL random seg=%0d got=%b want=%b", seg, obs(), expv());
                end
            end
        end
    endtask

    task automatic test_override();
        int rise_at, np;
        btn_raw2 = 1'b1;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({level2, press2, release2, bouncing2} !== 4'b0000) begin
            fails++;
            $display("FAIL ovr_reset got=%b want=0000",
                     {level2, press2, release2, bouncing2});
        end
        rst2 = 1'b0;
        rise_at = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (level2 === 1'b1 && rise_at < 0) begin
                rise_at = i;
                checks++;
                if (press2 !== 1'b1) begin
                    fails++;
                    $display("FAIL ovr_press got=%b want=1", press2);
                end
            end
        end
        checks++;
        if (rise_at !== 5) begin
            fails++;
            $display("FAIL ovr_latency got=%0d want=5", rise_at);
        end
        btn_raw2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (level2 !== 1'b0) begin
            fails++;
            $display("FAIL ovr_release got=%b want=0", level2);
        end
        np = 0;
        btn_raw2 = 1'b1;
        @(posedge clk);
        #1;
        btn_raw2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (press2 === 1'b1 || level2 === 1'b1) np++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (np !== 0) begin
            fails++;
            $display("FAIL ovr_glitch got=%0d want=0", np);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_boundary();
        test_reset_mid_check();
        test_random();
        test_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
